// File: rtl/u111_bus_arbiter_if.sv
// Local bus signals shared between the U111 bus arbiter and the parties it
// arbitrates: 68040 request/busy/lock inputs, external master requests, and
// the grant, buffer-direction and owner outputs.
interface u111_bus_arbiter_if;
  logic       BR_CPUn;
  logic       BB_CPUn;
  logic       LOCKn;
  logic [1:0] REQ;
  logic [1:0] GNT;
  logic       CPUBGn;
  logic       DMAn;
  logic [1:0] OWNER;

  // Arbiter side: samples requests, drives grants and ownership.
  modport master (
    input  BR_CPUn, BB_CPUn, LOCKn, REQ,
    output GNT, CPUBGn, DMAn, OWNER
  );

  // Requester side: the 68040 and the two external masters.
  modport slave (
    output BR_CPUn, BB_CPUn, LOCKn, REQ,
    input  GNT, CPUBGn, DMAn, OWNER
  );
endinterface

// File: rtl/u111_bus_arbiter.sv
// U111 local bus arbiter: shares the 68040 local bus between the CPU (parked
// default owner), Amiga chipset DMA (requester 0) and the PCI bridge
// (requester 1). All outputs are registered.
module u111_bus_arbiter #(
  parameter int unsigned HOLD_LIMIT = 64
) (
  input  logic CLK40,
  input  logic RESET,
  u111_bus_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(HOLD_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(HOLD_LIMIT);

  typedef enum logic [2:0] {
    CPU_OWN,
    CPU_REL,
    DEAD,
    EXT_OWN,
    TURN
  } state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic          rr;
  logic          sel;
  logic          competing;
  logic          pick;

  // Contention seen by the current external owner, and round-robin choice.
  always_comb begin
    competing = 1'b0;
    pick      = 1'b0;
    competing = !bus.BR_CPUn || bus.REQ[~sel];
    pick      = bus.REQ[rr] ? rr : ~rr;
  end

  // Ownership FSM with registered grant/ownership outputs.
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state      <= CPU_OWN;
      bus.CPUBGn <= 1'b0;
      bus.GNT    <= '0;
      bus.DMAn   <= 1'b1;
      bus.OWNER  <= 2'd0;
      hold_cnt   <= '0;
      rr         <= 1'b0;
      sel        <= 1'b0;
    end else begin
      case (state)
        CPU_OWN: begin
          if (bus.REQ != '0 && bus.LOCKn) begin
            state      <= CPU_REL;
            bus.CPUBGn <= 1'b1;
            bus.OWNER  <= 2'd3;
          end
        end
        CPU_REL: begin
          if (bus.REQ == '0) begin
            state      <= CPU_OWN;
            bus.CPUBGn <= 1'b0;
            bus.OWNER  <= 2'd0;
          end else if (bus.BB_CPUn) begin
            sel   <= pick;
            state <= DEAD;
          end
        end
        DEAD: begin
          state     <= EXT_OWN;
          hold_cnt  <= '0;
          bus.GNT   <= sel ? 2'b10 : 2'b01;
          bus.DMAn  <= 1'b0;
          bus.OWNER <= sel ? 2'd2 : 2'd1;
        end
        EXT_OWN: begin
          // Release wins over a limit hit in the same cycle; the grant is
          // withdrawn one edge after the counter has reached the limit.
          if (!bus.REQ[sel]) begin
            state     <= TURN;
            rr        <= ~sel;
            bus.GNT   <= '0;
            bus.DMAn  <= 1'b1;
            bus.OWNER <= 2'd3;
          end else begin
            if (hold_cnt == LIMIT) begin
              bus.GNT <= '0;
            end
            if (competing && hold_cnt != LIMIT) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        TURN: begin
          if (!bus.BR_CPUn) begin
            state      <= CPU_OWN;
            bus.CPUBGn <= 1'b0;
            bus.OWNER  <= 2'd0;
          end else if (bus.REQ[~sel]) begin
            sel   <= ~sel;
            state <= DEAD;
          end else begin
            state      <= CPU_OWN;
            bus.CPUBGn <= 1'b0;
            bus.OWNER  <= 2'd0;
          end
        end
        default: begin
          state      <= CPU_OWN;
          bus.CPUBGn <= 1'b0;
          bus.GNT    <= '0;
          bus.DMAn   <= 1'b1;
          bus.OWNER  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u111_bus_arbiter.sv
// Testbench for u111_bus_arbiter: directed scenarios followed by random
// traffic, with per-cycle expectations queued by the stimulus side and
// consumed by an independent monitor.
module tb_u111_bus_arbiter;

  localparam int H = 8;

  // Reference phases of bus ownership.
  localparam int P_CPU  = 0;
  localparam int P_REL  = 1;
  localparam int P_GAP  = 2;
  localparam int P_EXT  = 3;
  localparam int P_TURN = 4;

  typedef struct packed {
    logic       cpubgn;
    logic [1:0] gnt;
    logic       dman;
    logic [1:0] owner;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  u111_bus_arbiter_if bus();

  u111_bus_arbiter #(.HOLD_LIMIT(H)) dut (
    .CLK40 (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int phase = P_CPU;
  bit m_rr = 1'b0;
  bit m_sel = 1'b0;
  int busy_cycles = 0;
  bit granted = 1'b0;

  task automatic model_step(input logic [1:0] req, input logic br_n,
                            input logic bb_n, input logic lock_n,
                            input logic r);
    if (r) begin
      phase = P_CPU; m_rr = 0; m_sel = 0; busy_cycles = 0; granted = 0;
    end else begin
      case (phase)
        P_CPU: if (req != 2'b00 && lock_n) phase = P_REL;
        P_REL: begin
          if (req == 2'b00) phase = P_CPU;
          else if (bb_n) begin
            m_sel = req[m_rr] ? m_rr : !m_rr;
            phase = P_GAP;
          end
        end
        P_GAP: begin
          phase = P_EXT; busy_cycles = 0; granted = 1;
        end
        P_EXT: begin
          if (!req[m_sel]) begin
            phase = P_TURN; m_rr = !m_sel; granted = 0;
          end else begin
            // owner loses grant once it has been contended for H cycles
            if (busy_cycles >= H) granted = 0;
            if ((!br_n || req[!m_sel]) && busy_cycles < H) busy_cycles++;
          end
        end
        default: begin
          if (!br_n) phase = P_CPU;
          else if (req[!m_sel]) begin m_sel = !m_sel; phase = P_GAP; end
          else phase = P_CPU;
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    case (phase)
      P_CPU: e = '{cpubgn: 1'b0, gnt: 2'b00, dman: 1'b1, owner: 2'd0};
      P_EXT: e = '{cpubgn: 1'b1,
                   gnt: granted ? (m_sel ? 2'b10 : 2'b01) : 2'b00,
                   dman: 1'b0, owner: m_sel ? 2'd2 : 2'd1};
      default: e = '{cpubgn: 1'b1, gnt: 2'b00, dman: 1'b1, owner: 2'd3};
    endcase
    return e;
  endfunction

  // Drive one input pattern for n cycles, queueing the post-edge expectation.
  task automatic run(input logic [1:0] req, input logic br_n, input logic bb_n,
                     input logic lock_n, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.REQ = req; bus.BR_CPUn = br_n; bus.BB_CPUn = bb_n;
      bus.LOCKn = lock_n; rst = r;
      model_step(req, br_n, bb_n, lock_n, r);
      exp_q.push_back(model_out());
    end
  endtask

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: compares outputs after every edge against the queued model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (!bus.CPUBGn && bus.GNT != 2'b00) begin
        bad++;
        $display("FAIL inv_bg_gnt: CPUBGn=%0d GNT=%0d", bus.CPUBGn, bus.GNT);
      end
      total++;
      if (bus.GNT == 2'b11) begin
        bad++;
        $display("FAIL inv_gnt_onehot: GNT=%0d", bus.GNT);
      end
      total++;
      if (!bus.DMAn && !(bus.OWNER == 2'd1 || bus.OWNER == 2'd2)) begin
        bad++;
        $display("FAIL inv_dman_owner: DMAn=%0d OWNER=%0d", bus.DMAn, bus.OWNER);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cpubgn", int'(bus.CPUBGn), int'(e.cpubgn));
        check("gnt",    int'(bus.GNT),    int'(e.gnt));
        check("dman",   int'(bus.DMAn),   int'(e.dman));
        check("owner",  int'(bus.OWNER),  int'(e.owner));
      end
    end
  end

  initial begin
    logic [1:0] rq;
    logic       lk;
    rst = 1'b1; bus.REQ = 2'b00; bus.BR_CPUn = 1'b1;
    bus.BB_CPUn = 1'b0; bus.LOCKn = 1'b1;

    // Reset then idle: CPU stays parked owner
    run(2'b00, 1, 0, 1, 1, 2);
    run(2'b00, 1, 0, 1, 0, 100);

    // DMA request, CPU bus busy for two edges, release at edge 20
    run(2'b01, 1, 0, 1, 0, 2);
    run(2'b01, 1, 1, 1, 0, 18);
    run(2'b00, 1, 1, 1, 0, 6);

    // Locked sequence holds off PCI, then normal handover
    run(2'b10, 1, 1, 0, 0, 10);
    run(2'b10, 1, 1, 1, 0, 15);
    run(2'b00, 1, 1, 1, 0, 5);

    // Simultaneous requests from reset, sequence repeated twice
    run(2'b00, 1, 1, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin
      run(2'b11, 1, 1, 1, 0, 13);
      run(2'b10, 1, 1, 1, 0, 12);
      run(2'b00, 1, 1, 1, 0, 5);
      run(2'b01, 1, 1, 1, 0, 13);
      run(2'b11, 1, 1, 1, 0, 12);
      run(2'b00, 1, 1, 1, 0, 5);
    end

    // Hold limit: DMA keeps REQ while the CPU wants the bus
    run(2'b00, 1, 1, 1, 1, 1);
    run(2'b01, 0, 1, 1, 0, 20);
    run(2'b00, 0, 1, 1, 0, 5);

    // Reset pulsed while PCI owns the bus
    run(2'b10, 1, 1, 1, 0, 8);
    run(2'b10, 1, 1, 1, 1, 1);
    run(2'b10, 1, 1, 1, 0, 8);
    run(2'b00, 1, 1, 1, 0, 4);

    // Random traffic with persistent request lines
    rq = 2'b00; lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rq[0] = ~rq[0];
      if ($urandom_range(7) == 0) rq[1] = ~rq[1];
      if ($urandom_range(15) == 0) lk = ~lk;
      run(rq, logic'($urandom_range(3) == 0), logic'($urandom_range(3) != 0),
          lk, logic'($urandom_range(299) == 0), 1);
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u111_bus_arbiter.md
# u111_bus_arbiter

Local bus arbiter for the U111 68040 bus-sizing FPGA. It shares the 68040 local bus and its data buffers between the 68040 and two external bus masters: Amiga chipset DMA (requester 0) and the PCI bridge (requester 1). The CPU is the default (parked) owner. The block drives the CPU bus grant, the per-master grants and the DMA buffer-direction indicator, so that the cycle state machine and buffer logic always see exactly one owner.

## Interface
Parameters:
- HOLD_LIMIT, 64: cycles an external master may hold the bus while another party waits before its grant is withdrawn.

Ports (all synchronous to CLK40):
- CLK40  in  1  40MHz bus clock from the PLL; the only clock.
- RESET  in  1  synchronous, active-high reset.
- BR_CPUn  in  1  68040 bus request, active low.
- BB_CPUn  in  1  68040 bus busy, active low, sampled.
- LOCKn  in  1  68040 locked-sequence indicator, active low.
- REQ  in  2  external master requests, active high; [0] is DMA, [1] is PCI. Synchronous to CLK40.
- GNT  out  2  external master grants, active high, one-hot or zero.
- CPUBGn  out  1  bus grant to the 68040, active low.
- DMAn  out  1  low while an external master owns the bus.
- OWNER  out  2  owner code: 0 is CPU, 1 is DMA, 2 is PCI, 3 is none (handover).

## Operation
- All outputs are registered.
- Reset values: state CPU_OWN, CPUBGn=0, GNT=2'b00, DMAn=1, OWNER=0, hold counter=0, round-robin pointer RR=0.
- CPU_OWN: CPUBGn=0, OWNER=0.
  - When REQ!=0 and LOCKn=1, go to CPU_REL.
  - While LOCKn=0, stay regardless of REQ.
- CPU_REL: CPUBGn=1, OWNER=3.
  - If REQ==0, return to CPU_OWN (grant re-asserted).
  - Else, when BB_CPUn=1 is sampled, latch SEL and go to DEAD.
  - SEL is REQ[RR] if that request is set, otherwise the other requester.
- DEAD: one turnaround cycle. CPUBGn=1, GNT=0, DMAn=1. Go to EXT_OWN.
- EXT_OWN: GNT[SEL]=1, DMAn=0, OWNER=SEL+1.
  - Hold counter clears on entry. It increments each cycle that BR_CPUn=0 or REQ[~SEL]=1, and saturates at HOLD_LIMIT.
  - When the counter reaches HOLD_LIMIT, GNT[SEL] drops. This tells the master to start no new cycles. DMAn stays 0 and ownership is retained until the master releases.
  - When REQ[SEL]=0, go to TURN and set RR=~SEL.
- TURN: GNT=0, DMAn=1, OWNER=3, one cycle. Then:
  - if BR_CPUn=0, go to CPU_OWN;
  - else if REQ[~SEL]=1, set SEL=~SEL and go to DEAD;
  - else go to CPU_OWN (park).
- Invariants, which hold in every cycle:
  - never CPUBGn=0 together with GNT!=0;
  - never GNT=2'b11;
  - DMAn=0 only in EXT_OWN.
- Simultaneous REQ[0] and REQ[1] from CPU_OWN: RR decides. RR=0 after reset, so DMA wins.
- REQ[SEL] dropping in the same cycle the counter hits the limit: release takes precedence and the FSM goes to TURN.
- RESET asserted mid-operation: next edge returns to reset values, including CPUBGn=0. External masters must treat GNT=0 as an immediate abort.

## Timing
- REQ high sampled at edge 0 (in CPU_OWN, LOCKn=1): CPUBGn=1 after edge 0.
- BB_CPUn=1 sampled at edge k≥1: DEAD after edge k, GNT/DMAn asserted after edge k+1.
  - Minimum REQ-to-GNT latency is 3 edges.
- REQ[SEL] low sampled at edge m: TURN after edge m (GNT=0, DMAn=1).
  - CPUBGn=0 after edge m+1, or next master GNT after edge m+2.
- Hold limit: GNT drops after the edge on which the counter reaches HOLD_LIMIT. With a continuous competing request, that is HOLD_LIMIT+1 cycles of grant.
- Counter width is clog2(HOLD_LIMIT+1); no wrap.

## Test plan
- Reset with REQ=0: CPUBGn=0, GNT=0, DMAn=1, OWNER=0 after the first edge; these hold for 100 cycles.
- REQ=2'b01, BB_CPUn high at edge 2, REQ drops at edge 20 -> CPUBGn=1 from edge 0, GNT=2'b01 and DMAn=0 after edge 3, TURN after edge 20, CPUBGn=0 after edge 21.
- LOCKn=0 for 10 cycles with REQ=2'b10 -> CPUBGn stays 0 until LOCKn rises, then the normal handover to GNT=2'b10.
- REQ=2'b11 from reset, each held 10 cycles after grant then dropped -> DMA is granted first, PCI granted 2 cycles after DMA release, then the bus parks on the CPU. A repeat of the sequence grants PCI first.
- HOLD_LIMIT=8, DMA owner holds REQ while BR_CPUn=0 -> GNT[0] drops after 9 grant cycles with DMAn still 0; after REQ drops, CPUBGn=0 two edges later.
- RESET pulsed during EXT_OWN -> GNT=0, DMAn=1, CPUBGn=0 after that edge; the invariants checker never fires.
